// File: rtl/dmem_rmw_ctrl.sv
// rtl/dmem_rmw_ctrl.sv - data-memory sequencer: word pass-through, byte-store read-modify-write (optional DMEM_RMW_ALIGN_CHECK_EN)
module dmem_rmw_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              is_store,
   input  logic              is_byte,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       merge_word,
   output logic              busy,
   output logic              done,
   output logic [31:0]       mem_word,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef DMEM_RMW_ALIGN_CHECK_EN
   ,
   output logic              misalign
`endif
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR       = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   // Counter value loaded in RD_ISSUE; it reaches zero in the cycle the RAM data is valid.
   localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

   state_t            r_state;
   state_t            w_nxt_state;

   logic              r_op_store;
   logic              r_op_byte;
   logic [ADDR_W-1:2] r_addr_q;
   logic [31:0]       r_wdata_q;
   logic [31:0]       r_mem_word;
   logic [1:0]        r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_mem_en;
   logic              r_mem_we;

   logic              w_accept;
   logic              w_misalign_req;
   logic              w_byte_wr;
   logic              w_rd_last;

   assign w_accept  = (r_state == S_IDLE) && req;
   assign w_rd_last = (r_state == S_RD_WAIT) && (r_cnt == 2'd0);
   assign w_byte_wr = (r_state == S_WR) && r_op_byte;

`ifdef DMEM_RMW_ALIGN_CHECK_EN
   logic r_misalign;

   assign w_misalign_req = !is_byte && (addr[1:0] != 2'b00);
   assign misalign       = r_misalign;
`else
   // Low address bits are dropped entirely when alignment checking is not built in.
   logic w_unused_addr_lo;

   assign w_unused_addr_lo = ^addr[1:0];
   assign w_misalign_req   = 1'b0;
`endif

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next-state decode; word stores skip the read, byte stores read then write.
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               if (w_misalign_req) begin
                  w_nxt_state = S_RESP;
               end else if (is_store && !is_byte) begin
                  w_nxt_state = S_WR;
               end else begin
                  w_nxt_state = S_RD_ISSUE;
               end
            end
         end
         S_RD_ISSUE: begin
            w_nxt_state = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (r_cnt == 2'd0) begin
               w_nxt_state = r_op_store ? S_WR : S_RESP;
            end
         end
         S_WR: begin
            w_nxt_state = S_RESP;
         end
         S_RESP: begin
            w_nxt_state = S_IDLE;
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   // Control outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
      end else begin
         r_busy   <= (w_nxt_state != S_IDLE);
         r_done   <= (w_nxt_state == S_RESP);
         r_mem_en <= (w_nxt_state == S_RD_ISSUE) || (w_nxt_state == S_WR);
         r_mem_we <= (w_nxt_state == S_WR);
      end
   end

   // Capture the request operands when an access is accepted in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_store <= 1'b0;
         r_op_byte  <= 1'b0;
         r_addr_q   <= '0;
         r_wdata_q  <= '0;
      end else if (w_accept) begin
         r_op_store <= is_store;
         r_op_byte  <= is_byte;
         r_addr_q   <= addr[ADDR_W-1:2];
         r_wdata_q  <= wdata;
      end
   end

   // Read-latency counter and read-data capture; stores never touch the captured word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt      <= 2'd0;
         r_mem_word <= '0;
      end else begin
         if (r_state == S_RD_ISSUE) begin
            r_cnt <= LAT_M1;
         end else if ((r_state == S_RD_WAIT) && (r_cnt != 2'd0)) begin
            r_cnt <= r_cnt - 2'd1;
         end
         if (w_rd_last) begin
            r_mem_word <= mem_rdata;
         end
      end
   end

`ifdef DMEM_RMW_ALIGN_CHECK_EN
   // Misalign flag pulses together with done for a rejected misaligned word access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_accept && w_misalign_req;
      end
   end
`endif

   assign busy     = r_busy;
   assign done     = r_done;
   assign mem_en   = r_mem_en;
   assign mem_we   = r_mem_we;
   assign mem_word = r_mem_word;
   assign mem_addr = {r_addr_q, 2'b00};

   // The BAC merges against mem_word, which only becomes stable in the WR cycle itself,
   // so a byte-store write takes merge_word straight through during WR.
   assign mem_wdata = w_byte_wr ? merge_word : r_wdata_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb/tb_dmem_rmw_ctrl.sv - scoreboard bench for dmem_rmw_ctrl with byte-addressed reference memory
module tb_dmem_rmw_ctrl;

   localparam int TB_LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        is_store = 1'b0;
   logic        is_byte = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] merge_word;
   logic        busy;
   logic        done;
   logic [31:0] mem_word;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef DMEM_RMW_ALIGN_CHECK_EN
   logic        misalign;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        mis;
   } ev_t;

   ev_t rd_q[$];
   ev_t wr_q[$];
   ev_t rs_q[$];
   ev_t m_e;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   logic [7:0]  ref_b [0:255];
   logic [31:0] exp_mem_word = 32'h0;

   logic [1:0]  bac_lane = 2'd0;
   logic [7:0]  bac_byte = 8'h0;

   logic [31:0] ram [0:63];
   logic [31:0] rd_pipe [0:TB_LAT-1];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_val = 32'h0;

   dmem_rmw_ctrl #(
      .ADDR_W  (32),
      .MEM_LAT (TB_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .is_store   (is_store),
      .is_byte    (is_byte),
      .addr       (addr),
      .wdata      (wdata),
      .merge_word (merge_word),
      .busy       (busy),
      .done       (done),
      .mem_word   (mem_word),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef DMEM_RMW_ALIGN_CHECK_EN
      ,
      .misalign   (misalign)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BAC model: replace the addressed byte lane of the captured word.
   always_comb begin
      merge_word = mem_word;
      merge_word[{bac_lane, 3'b000} +: 8] = bac_byte;
   end

   // Word RAM with TB_LAT read latency; idle cycles present random garbage.
   always @(posedge clk) begin
      for (int i = TB_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:2]] : $urandom;
      if (mem_en && mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      if (pl_en) ram[pl_idx] <= pl_val;
   end
   assign mem_rdata = rd_pipe[TB_LAT-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [31:0] ref_word(input int base);
      return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
   endfunction

   // Monitor: every RAM access and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (mem_en && !mem_we) begin
         chk("rd_expected", rd_q.size() != 0, 1);
         if (rd_q.size() != 0) begin
            m_e = rd_q.pop_front();
            chk("rd_addr", mem_addr, m_e.adr);
            chk("rd_cycle", cyc, m_e.cyc);
         end
      end
      if (mem_en && mem_we) begin
         chk("wr_expected", wr_q.size() != 0, 1);
         if (wr_q.size() != 0) begin
            m_e = wr_q.pop_front();
            chk("wr_addr", mem_addr, m_e.adr);
            chk("wr_data", mem_wdata, m_e.dat);
            chk("wr_cycle", cyc, m_e.cyc);
         end
      end
      if (done) begin
         chk("done_expected", rs_q.size() != 0, 1);
         if (rs_q.size() != 0) begin
            m_e = rs_q.pop_front();
            chk("resp_mem_word", mem_word, m_e.dat);
            chk("done_cycle", cyc, m_e.cyc);
`ifdef DMEM_RMW_ALIGN_CHECK_EN
            chk("resp_misalign", misalign, m_e.mis);
`endif
         end
      end
   end

   task automatic push_exp(input bit st, input bit by, input logic [7:0] a,
                           input logic [31:0] wd, input int t0);
      int          base;
      logic [31:0] old;
      base = int'({a[7:2], 2'b00});
      old  = ref_word(base);
`ifdef DMEM_RMW_ALIGN_CHECK_EN
      if (!by && a[1:0] != 2'b00) begin
         rs_q.push_back('{t0 + 1, 32'h0, exp_mem_word, 1'b1});
         return;
      end
`endif
      if (!st) begin
         rd_q.push_back('{t0 + 1, 32'(base), 32'h0, 1'b0});
         rs_q.push_back('{t0 + 2 + TB_LAT, 32'h0, old, 1'b0});
         exp_mem_word = old;
      end else if (!by) begin
         for (int k = 0; k < 4; k++) ref_b[base+k] = wd[8*k +: 8];
         wr_q.push_back('{t0 + 1, 32'(base), wd, 1'b0});
         rs_q.push_back('{t0 + 2, 32'h0, exp_mem_word, 1'b0});
      end else begin
         rd_q.push_back('{t0 + 1, 32'(base), 32'h0, 1'b0});
         ref_b[a] = wd[7:0];
         wr_q.push_back('{t0 + 2 + TB_LAT, 32'(base), ref_word(base), 1'b0});
         rs_q.push_back('{t0 + 3 + TB_LAT, 32'h0, old, 1'b0});
         exp_mem_word = old;
      end
   endtask

   task automatic drive(input bit st, input bit by, input logic [7:0] a, input logic [31:0] wd);
      is_store = st;
      is_byte  = by;
      addr     = {24'h0, a};
      wdata    = wd;
      bac_lane = a[1:0];
      bac_byte = wd[7:0];
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic set_word(input logic [7:0] a, input logic [31:0] w);
      int base;
      base   = int'({a[7:2], 2'b00});
      pl_en  = 1'b1;
      pl_idx = a[7:2];
      pl_val = w;
      for (int k = 0; k < 4; k++) ref_b[base+k] = w[8*k +: 8];
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic do_op(input bit st, input bit by, input logic [7:0] a, input logic [31:0] wd);
      wait_idle();
      drive(st, by, a, wd);
      push_exp(st, by, a, wd, cyc);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          t0;
      logic [31:0] wd;
      logic [7:0]  ra;

      rst_n = 1'b0;
      req   = 1'b1;
      drive(1'b1, 1'b0, 8'h40, 32'h1234_5678);
      repeat (2) begin
         @(negedge clk);
         chk("reset_busy", busy, 0);
         chk("reset_done", done, 0);
         chk("reset_mem_en", mem_en, 0);
         chk("reset_mem_we", mem_we, 0);
         chk("reset_mem_word", mem_word, 0);
         chk("reset_mem_addr", mem_addr, 0);
         chk("reset_mem_wdata", mem_wdata, 0);
      end
      req = 1'b0;
      for (int i = 0; i < 64; i++) set_word(8'(i * 4), $urandom);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", busy, 0);

      do_op(1'b1, 1'b0, 8'h40, 32'h1234_5678);

      wait_idle();
      set_word(8'h40, 32'h7890_1234);
      do_op(1'b1, 1'b1, 8'h41, 32'h1234_5678);

      wait_idle();
      set_word(8'h80, 32'hDEAD_BEEF);
      wait_idle();
      drive(1'b0, 1'b0, 8'h80, 32'h0);
      push_exp(1'b0, 1'b0, 8'h80, 32'h0, cyc);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h44, $urandom);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;

      wait_idle();
      t0 = cyc;
      wd = $urandom;
      drive(1'b1, 1'b0, 8'h10, wd);
      push_exp(1'b1, 1'b0, 8'h10, wd, t0);
      push_exp(1'b1, 1'b0, 8'h10, wd, t0 + 3);
      req = 1'b1;
      repeat (4) @(negedge clk);
      req = 1'b0;

      wait_idle();
      t0 = cyc;
      drive(1'b1, 1'b1, 8'h22, $urandom);
      rd_q.push_back('{t0 + 1, 32'h20, 32'h0, 1'b0});
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_busy", busy, 0);
      chk("midreset_mem_word", mem_word, 0);
      rst_n = 1'b1;
      exp_mem_word = 32'h0;
      repeat (8) @(negedge clk);

`ifdef DMEM_RMW_ALIGN_CHECK_EN
      do_op(1'b0, 1'b0, 8'h42, 32'h0);
      do_op(1'b0, 1'b1, 8'h42, 32'h0);
`endif

      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom_range(0, 255));
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      wait_idle();
      repeat (10) @(negedge clk);
      chk("rd_q_drained", rd_q.size(), 0);
      chk("wr_q_drained", wr_q.size(), 0);
      chk("rs_q_drained", rs_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_rmw_ctrl.md
Name: dmem_rmw_ctrl

Overview:
- Multi-cycle data-memory sequencer directly downstream of the byte access converter (BAC). It drives a word-only synchronous data RAM.
- Word loads and stores pass straight through to the RAM.
- Byte stores become read-modify-write: the controller reads the aligned word and hands it to the BAC as its memory-word input. It then writes back the merged word the BAC returns.
- Load data is returned as the full aligned word, so the BAC can extract the byte.

Parameters:
- ADDR_W, 32: CPU address width.
- MEM_LAT, 1: RAM read latency in cycles, legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- req  input  1  access request; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- is_byte  input  1  1 = byte access, 0 = word access.
- addr  input  ADDR_W  aligned address from BAC Aout.
- wdata  input  32  word store data.
- merge_word  input  32  merged store word from BAC Dout1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- mem_word  output  32  captured RAM word; drives BAC Din2 and serves as load data.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address, equal to {addr_q[ADDR_W-1:2], 2'b00}.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid MEM_LAT cycles after the read cycle.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state <= IDLE.
  - busy, done, mem_en, mem_we <= 0.
  - mem_addr, mem_wdata, mem_word <= 0; wait counter <= 0.
  - Reset has priority over everything. Reset mid-operation aborts the access: no write may be issued in any cycle after the reset edge.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP. All outputs are registered.
- IDLE:
  - If req=1, latch is_store, is_byte, addr and wdata into op_q, addr_q and wdata_q.
  - Next state is WR when (is_store and not is_byte); otherwise RD_ISSUE.
  - If req=0, stay in IDLE.
- RD_ISSUE: mem_en=1, mem_we=0, mem_addr=aligned addr_q. Load counter with MEM_LAT-1, then go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture mem_rdata into mem_word.
  - Next state: load goes to RESP; byte store goes to WR.
  - mem_en=0 throughout RD_WAIT.
- WR:
  - mem_en=1, mem_we=1, mem_addr = aligned addr_q.
  - mem_wdata = merge_word for a byte store, wdata_q for a word store.
  - merge_word is sampled in this cycle; the BAC sees the stable mem_word from the prior cycle.
  - Next state RESP.
- RESP: done=1 for exactly one cycle, mem_en=0, then IDLE.
- mem_word holds its value until the next read capture. Stores never overwrite it.
- Cycle counts (req sampled at cycle 0, L = MEM_LAT):
  - Word or byte load: done at cycle 2+L.
  - Word store: write at cycle 1, done at cycle 2.
  - Byte store: read at cycle 1, write at cycle 2+L, done at cycle 3+L.
- Requests arriving while busy=1 are ignored; they are not queued.
- Back-to-back requests are separated by a minimum of one IDLE cycle after RESP.
- req held high continuously starts a new access on each IDLE entry.
- Address bits [1:0] are ignored for the RAM address.

Optional Feature:
- Macro: DMEM_RMW_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign (1 bit).
  - A word access (is_byte=0) with addr[1:0]!=0 accepted in IDLE goes directly to RESP.
  - No RAM enable is asserted for that access.
  - done=1 and misalign=1 together for one cycle; mem_word is unchanged.
  - misalign resets to 0.
- When not defined: no misalign port exists, and the low address bits are silently dropped.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req=1 -> busy=0, done=0, mem_en=0, mem_word=0. No access starts until after rst_n=1.
2. Word store, L=1: addr=0x40, wdata=0x1234_5678 -> cycle 1 mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x1234_5678; done=1 at cycle 2.
3. Byte store, L=1: addr=0x41, wdata=0x1234_5678, RAM[0x40]=0x7890_1234. Bench BAC model returns merge_word=0x7890_7834 -> read at cycle 1; mem_word=0x7890_1234; write 0x7890_7834 to 0x40 at cycle 3; done at cycle 4.
4. Word load, L=3: RAM[0x80]=0xDEAD_BEEF -> mem_word=0xDEAD_BEEF and done=1 at cycle 5. A second req pulse at cycle 2 is ignored.
5. Reset mid byte store: assert rst_n=0 during RD_WAIT -> next cycle state IDLE, and mem_we never asserted for that access.
6. With DMEM_RMW_ALIGN_CHECK_EN: word load at addr=0x42 -> done=1 and misalign=1 at cycle 1, mem_en stays 0. Byte load at 0x42 proceeds normally with misalign=0.
